// File: rtl/mad_io_port_ctrl.sv
// Host-side In/Out/Int peripheral: input FIFO feeding the processor In bus, output FIFO
// capturing Out, and an Int pulse generator. Optional loopback via `MAD_IO_LOOPBACK_EN.
module mad_io_port_ctrl #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned INT_CYCLES = 2,
    parameter logic [15:0] IDLE_WORD  = 16'h0000
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [15:0]                host_in_data,
    input  logic                       host_in_valid,
    output logic                       host_in_ready,
    output logic [15:0]                In,
    input  logic                       cpu_in_rd,
    input  logic [15:0]                Out,
    input  logic                       cpu_out_wr,
`ifdef MAD_IO_LOOPBACK_EN
    input  logic                       loopback,
`endif
    output logic [15:0]                host_out_data,
    output logic                       host_out_valid,
    input  logic                       host_out_ready,
    output logic                       Int,
    output logic [$clog2(DEPTH):0]     in_count,
    output logic                       in_underflow,
    output logic                       out_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NW = AW + 1;
    localparam int unsigned CW = $clog2(INT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} int_state_t;

    logic [15:0]   imem [DEPTH];
    logic [AW-1:0] i_rd, i_wr;
    logic [NW-1:0] i_cnt;
    logic [15:0]   omem [DEPTH];
    logic [AW-1:0] o_rd, o_wr;
    logic [NW-1:0] o_cnt;

    logic          lb;
    logic          i_full, i_empty, i_push, i_pop;
    logic [15:0]   i_wdata;
    logic          o_full, o_push, o_pop;
    logic          ovf_evt, udf_evt;

    int_state_t    state, state_nx;
    logic [CW-1:0] pcnt, pcnt_nx;

`ifdef MAD_IO_LOOPBACK_EN
    assign lb = loopback;
`else
    assign lb = 1'b0;
`endif

    always_comb begin
        i_full         = (i_cnt == NW'(DEPTH));
        i_empty        = (i_cnt == '0);
        o_full         = (o_cnt == NW'(DEPTH));
        host_in_ready  = !i_full && !lb;
        host_out_valid = (o_cnt != '0);
        host_out_data  = host_out_valid ? omem[o_rd] : '0;
        In             = i_empty ? IDLE_WORD : imem[i_rd];

        // Loopback steals the input FIFO write port, so the host is refused that cycle.
        i_push  = lb ? (cpu_out_wr && !i_full) : (host_in_valid && !i_full);
        i_wdata = lb ? Out : host_in_data;
        i_pop   = cpu_in_rd && !i_empty;
        udf_evt = cpu_in_rd && i_empty;

        o_pop   = host_out_valid && host_out_ready;
        o_push  = cpu_out_wr && !lb && (!o_full || o_pop);
        ovf_evt = cpu_out_wr && (lb ? i_full : (o_full && !o_pop));
    end

    assign in_count = i_cnt;

    always_ff @(posedge Clk) begin
        if (i_push) imem[i_wr] <= i_wdata;
        if (o_push) omem[o_wr] <= Out;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            i_rd         <= '0;
            i_wr         <= '0;
            i_cnt        <= '0;
            o_rd         <= '0;
            o_wr         <= '0;
            o_cnt        <= '0;
            in_underflow <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            if (i_push) i_wr <= i_wr + AW'(1);
            if (i_pop)  i_rd <= i_rd + AW'(1);
            case ({i_push, i_pop})
                2'b10:   i_cnt <= i_cnt + NW'(1);
                2'b01:   i_cnt <= i_cnt - NW'(1);
                default: i_cnt <= i_cnt;
            endcase

            if (o_push) o_wr <= o_wr + AW'(1);
            if (o_pop)  o_rd <= o_rd + AW'(1);
            case ({o_push, o_pop})
                2'b10:   o_cnt <= o_cnt + NW'(1);
                2'b01:   o_cnt <= o_cnt - NW'(1);
                default: o_cnt <= o_cnt;
            endcase

            in_underflow <= in_underflow | udf_evt;
            out_overflow <= out_overflow | ovf_evt;
        end
    end

    // Interrupt only on empty->non-empty; HOLDOFF waits for a full drain before re-arming.
    always_comb begin
        state_nx = state;
        pcnt_nx  = pcnt;
        case (state)
            IDLE: begin
                if (i_push && i_empty) begin
                    state_nx = PULSE;
                    pcnt_nx  = CW'(INT_CYCLES - 1);
                end
            end
            PULSE: begin
                if (pcnt == '0) state_nx = HOLDOFF;
                else            pcnt_nx  = pcnt - CW'(1);
            end
            HOLDOFF: begin
                if (i_empty) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            pcnt  <= '0;
            Int   <= 1'b0;
        end else begin
            state <= state_nx;
            pcnt  <= pcnt_nx;
            Int   <= (state_nx == PULSE);
        end
    end

endmodule

// File: tb/tb_mad_io_port_ctrl.sv
// Scoreboard bench for mad_io_port_ctrl: expected words queued at drive time,
// compared when the processor reads In or the host drains the output FIFO.
module tb_mad_io_port_ctrl;

    localparam int unsigned DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [15:0] host_in_data = '0;
    logic        host_in_valid = 1'b0;
    logic        host_in_ready;
    logic [15:0] In;
    logic        cpu_in_rd = 1'b0;
    logic [15:0] Out = '0;
    logic        cpu_out_wr = 1'b0;
    logic [15:0] host_out_data;
    logic        host_out_valid;
    logic        host_out_ready = 1'b0;
    logic        Int;
    logic [2:0]  in_count;
    logic        in_underflow;
    logic        out_overflow;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned int_hi = 0;
    int unsigned int_rises = 0;
    logic        int_prev = 1'b0;

    logic [15:0] in_q[$];
    logic [15:0] out_q[$];

    mad_io_port_ctrl #(.DEPTH(4), .INT_CYCLES(2), .IDLE_WORD(16'h0000)) dut (
        .Clk(Clk), .Rst(Rst),
        .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
        .In(In), .cpu_in_rd(cpu_in_rd), .Out(Out), .cpu_out_wr(cpu_out_wr),
`ifdef MAD_IO_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .host_out_data(host_out_data), .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
        .Int(Int), .in_count(in_count), .in_underflow(in_underflow), .out_overflow(out_overflow)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Int) int_hi++;
        if (Int && !int_prev) int_rises++;
        int_prev = Int;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic host_push(input logic [15:0] w);
        check_eq("host_in_ready", {31'b0, host_in_ready}, {31'b0, in_q.size() < DEPTH});
        host_in_data  = w;
        host_in_valid = 1'b1;
        if (in_q.size() < DEPTH) in_q.push_back(w);
        tick();
        host_in_valid = 1'b0;
    endtask

    task automatic cpu_pop();
        cpu_in_rd = 1'b1;
        if (in_q.size() > 0) check_eq("in_bus", {16'b0, In}, {16'b0, in_q.pop_front()});
        else                 check_eq("in_idle", {16'b0, In}, 32'h0);
        tick();
        cpu_in_rd = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] w);
        Out        = w;
        cpu_out_wr = 1'b1;
        if (out_q.size() < DEPTH) out_q.push_back(w);
        tick();
        cpu_out_wr = 1'b0;
    endtask

    task automatic host_drain_one();
        host_out_ready = 1'b1;
        check_eq("out_valid", {31'b0, host_out_valid}, 32'h1);
        check_eq("out_data", {16'b0, host_out_data}, {16'b0, out_q.pop_front()});
        tick();
        host_out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] words[4];
        words = '{16'h0020, 16'hFFFF, 16'hF320, 16'hAABD};

        // reset
        tick();
        Rst = 1'b0;
        check_eq("rst_in", {16'b0, In}, 32'h0);
        check_eq("rst_int", {31'b0, Int}, 32'h0);
        check_eq("rst_ready", {31'b0, host_in_ready}, 32'h1);
        check_eq("rst_out_valid", {31'b0, host_out_valid}, 32'h0);
        check_eq("rst_out_data", {16'b0, host_out_data}, 32'h0);
        check_eq("rst_count", {29'b0, in_count}, 32'h0);
        check_eq("rst_udf", {31'b0, in_underflow}, 32'h0);
        check_eq("rst_ovf", {31'b0, out_overflow}, 32'h0);

        // first push and Int pulse
        host_push(16'h0004);
        check_eq("first_in", {16'b0, In}, 32'h0004);
        check_eq("int_c1", {31'b0, Int}, 32'h1);
        tick();
        check_eq("int_c2", {31'b0, Int}, 32'h1);
        tick();
        check_eq("int_c3", {31'b0, Int}, 32'h0);
        cpu_pop();
        tick(2);

        // ordered drain and underflow
        foreach (words[i]) host_push(words[i]);
        check_eq("full_count", {29'b0, in_count}, 32'd4);
        check_eq("full_ready", {31'b0, host_in_ready}, 32'h0);
        for (int i = 0; i < 4; i++) cpu_pop();
        check_eq("drain_count", {29'b0, in_count}, 32'd0);
        check_eq("pre_udf", {31'b0, in_underflow}, 32'h0);
        cpu_pop();
        check_eq("udf_set", {31'b0, in_underflow}, 32'h1);
        tick(2);

        // full input FIFO with simultaneous pop
        for (int i = 0; i < 4; i++) host_push(16'h0010 + 16'(i));
        check_eq("full_ready2", {31'b0, host_in_ready}, 32'h0);
        host_in_data  = 16'h1234;
        host_in_valid = 1'b1;
        cpu_pop();
        host_in_valid = 1'b0;
        check_eq("pop_full_count", {29'b0, in_count}, 32'd3);
        host_push(16'h1234);
        check_eq("retry_count", {29'b0, in_count}, 32'd4);
        for (int i = 0; i < 4; i++) cpu_pop();
        check_eq("empty_idle", {16'b0, In}, 32'h0);
        tick(2);

        // output backpressure and overflow
        for (int i = 1; i <= 5; i++) cpu_write(16'(i));
        check_eq("ovf_set", {31'b0, out_overflow}, 32'h1);
        check_eq("hold_data1", {16'b0, host_out_data}, 32'h0001);
        tick();
        check_eq("hold_data2", {16'b0, host_out_data}, 32'h0001);
        // full + host pop same cycle: write is accepted
        host_out_ready = 1'b1;
        Out            = 16'h00A5;
        cpu_out_wr     = 1'b1;
        check_eq("out_data", {16'b0, host_out_data}, {16'b0, out_q.pop_front()});
        out_q.push_back(16'h00A5);
        tick();
        cpu_out_wr     = 1'b0;
        host_out_ready = 1'b0;
        while (out_q.size() > 0) host_drain_one();
        check_eq("out_empty", {31'b0, host_out_valid}, 32'h0);

        // Int holdoff
        int_hi    = 0;
        int_rises = 0;
        host_push(16'h0A0A);
        tick(3);
        host_push(16'h0B0B);
        tick(4);
        check_eq("holdoff_rises", int_rises, 32'd1);
        check_eq("holdoff_hi", int_hi, 32'd2);
        cpu_pop();
        cpu_pop();
        tick(2);
        host_push(16'h0C0C);
        tick(4);
        check_eq("rearm_rises", int_rises, 32'd2);
        check_eq("rearm_hi", int_hi, 32'd4);
        cpu_pop();
        tick(2);

        // reset mid-pulse discards data and the pulse
        host_push(16'h55AA);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        in_q.delete();
        check_eq("mrst_count", {29'b0, in_count}, 32'd0);
        check_eq("mrst_int", {31'b0, Int}, 32'h0);
        check_eq("mrst_in", {16'b0, In}, 32'h0);
        check_eq("mrst_udf", {31'b0, in_underflow}, 32'h0);
        check_eq("mrst_ovf", {31'b0, out_overflow}, 32'h0);
        int_hi = 0;
        tick(3);
        check_eq("mrst_no_pulse", int_hi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
